// File: rtl/nn_pkg.sv
// Shared constants, value type and helpers for the small CNN inference pipeline.
package nn_pkg;
    localparam int DEFAULT_VALUE_BITS      = 32;
    typedef logic signed [DEFAULT_VALUE_BITS-1:0] value_t;

    localparam int KERNEL_HEIGHT           = 3;
    localparam int KERNEL_WIDTH            = 3;
    localparam int CONV2D_1_FILTERS_NUMBER = 2;
    localparam int POOL_SIZE               = 2;

    // Valid-padding pooled size: a trailing odd row/column is dropped.
    function automatic int pool_out_size(input int n);
        return n / POOL_SIZE;
    endfunction

    function automatic value_t smax(input value_t a, input value_t b);
        return (a >= b) ? a : b;
    endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// Register-array line buffer: one synchronous write port, one combinational read port.
module pool_line_buffer #(
    parameter int DEPTH = 13,
    parameter int WIDTH = 32,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/maxpool2d_stream.sv
// 2x2 stride-2 max pooling over a raster, channel-interleaved valid/ready stream.
module maxpool2d_stream
    import nn_pkg::*;
#(
    parameter int INPUT_HEIGHT = 26,
    parameter int INPUT_WIDTH  = 26,
    parameter int CHANNELS     = CONV2D_1_FILTERS_NUMBER,
    parameter int VALUE_BITS   = DEFAULT_VALUE_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [VALUE_BITS-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [VALUE_BITS-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);
    localparam int PW       = pool_out_size(INPUT_WIDTH);
    localparam int PH       = pool_out_size(INPUT_HEIGHT);
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int COLW     = $clog2(INPUT_WIDTH);
    localparam int ROWW     = $clog2(INPUT_HEIGHT);
    localparam int LB_DEPTH = PW * CHANNELS;
    localparam int LBAW     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CHW-1:0]  CH_LAST  = CHW'(CHANNELS - 1);
    localparam logic [COLW-1:0] COL_LAST = COLW'(INPUT_WIDTH - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(INPUT_HEIGHT - 1);
    localparam logic [COLW-1:0] COL_WIN  = COLW'(2 * PW - 1);
    localparam logic [ROWW-1:0] ROW_WIN  = ROWW'(2 * PH - 1);

    function automatic logic signed [VALUE_BITS-1:0] vmax(
        input logic signed [VALUE_BITS-1:0] a,
        input logic signed [VALUE_BITS-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    logic [CHW-1:0]  ch;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;

    logic signed [VALUE_BITS-1:0] hold [2**CHW];
    logic signed [VALUE_BITS-1:0] h_max, lb_rd, pooled;
    logic [LBAW-1:0]              lb_addr;
    logic accept, in_win, lb_wr, load, win_last;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Trailing odd row/column beats fall outside the window and are consumed silently.
    assign in_win   = (col <= COL_WIN) && (row <= ROW_WIN);
    assign lb_wr    = accept && in_win && col[0] && !row[0];
    assign load     = accept && in_win && col[0] && row[0];
    assign win_last = (row == ROW_WIN) && (col == COL_WIN) && (ch == CH_LAST);
    assign lb_addr  = LBAW'((int'(col) / 2) * CHANNELS + int'(ch));
    assign h_max    = vmax(hold[ch], in_data);
    assign pooled   = vmax(lb_rd, h_max);

    pool_line_buffer #(.DEPTH(LB_DEPTH), .WIDTH(VALUE_BITS)) u_lbuf (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_addr (lb_addr),
        .wr_data (h_max),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    always_ff @(posedge clk) begin
        if (accept && in_win && !col[0]) hold[ch] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (ch == CH_LAST) begin
                ch <= '0;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROWW'(1);
                end else begin
                    col <= col + COLW'(1);
                end
            end else begin
                ch <= ch + CHW'(1);
            end
        end
    end

    // A load can coincide with a drain; load wins so no bubble appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= pooled;
            out_valid <= 1'b1;
            out_last  <= win_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_maxpool2d_stream.sv
// Drives three differently sized pooling instances and checks them against a frame-array model.
module tb_maxpool2d_stream;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [31:0] in_data  [NI];
    logic signed [31:0] out_data [NI];
    logic in_valid [NI], in_ready [NI], out_valid [NI], out_ready [NI], out_last [NI];

    always #5 clk = ~clk;

    maxpool2d_stream #(.INPUT_HEIGHT(4), .INPUT_WIDTH(4), .CHANNELS(1), .VALUE_BITS(32)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_last(out_last[0]));
    maxpool2d_stream #(.INPUT_HEIGHT(2), .INPUT_WIDTH(2), .CHANNELS(2), .VALUE_BITS(32)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_last(out_last[1]));
    maxpool2d_stream #(.INPUT_HEIGHT(5), .INPUT_WIDTH(5), .CHANNELS(1), .VALUE_BITS(32)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_last(out_last[2]));

    int hh [NI] = '{4, 2, 5};
    int ww [NI] = '{4, 2, 5};
    int cc [NI] = '{1, 2, 1};

    int pos [NI];
    int fb [NI][64];
    int eq_d [NI][512];
    bit eq_l [NI][512];
    int eh [NI], et [NI];
    bit due_f [NI][4];
    int due_v [NI][4];
    int logd [NI][16];
    bit logl [NI][16];
    int logn [NI];
    int cyc = 0;
    int checks = 0, errors = 0;
    bit rnd_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int k, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst=%0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    function automatic int fidx(input int k, input int r, input int c, input int ch);
        return (r * ww[k] + c) * cc[k] + ch;
    endfunction

    // Frame-level model: keep every beat of the frame, and whenever the beat
    // closing a 2x2 window arrives, take the max of its four pixels.
    task automatic model_beat(input int k, input int v);
        int r, c, ch, m, a;
        r  = pos[k] / (ww[k] * cc[k]);
        c  = (pos[k] / cc[k]) % ww[k];
        ch = pos[k] % cc[k];
        fb[k][pos[k]] = v;
        if (r % 2 == 1 && c % 2 == 1 && r < (hh[k] / 2) * 2 && c < (ww[k] / 2) * 2) begin
            m = fb[k][fidx(k, r - 1, c - 1, ch)];
            a = fb[k][fidx(k, r - 1, c, ch)]; if (a > m) m = a;
            a = fb[k][fidx(k, r, c - 1, ch)]; if (a > m) m = a;
            a = fb[k][fidx(k, r, c, ch)];     if (a > m) m = a;
            eq_d[k][et[k] % 512] = m;
            eq_l[k][et[k] % 512] = (r == (hh[k] / 2) * 2 - 1) && (c == (ww[k] / 2) * 2 - 1) && (ch == cc[k] - 1);
            et[k]++;
            due_f[k][(cyc + 1) % 4] = 1'b1;
            due_v[k][(cyc + 1) % 4] = m;
        end
        pos[k] = (pos[k] + 1) % (hh[k] * ww[k] * cc[k]);
    endtask

    task automatic sync();
        @(posedge clk); #2;
    endtask

    task automatic send(input int k, input int v);
        int t = 0;
        in_data[k]  = v;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && t < 200) begin
            sync();
            t++;
        end
        if (!in_ready[k]) begin
            check(1'b0, "in_ready_timeout", k, 0, 1);
            in_valid[k] = 1'b0;
            return;
        end
        model_beat(k, v);
        sync();
        in_valid[k] = 1'b0;
    endtask

    task automatic do_reset();
        for (int k = 0; k < NI; k++) in_valid[k] = 1'b0;
        rst_n = 1'b0;
        repeat (3) sync();
        for (int k = 0; k < NI; k++) begin
            check(eh[k] == et[k], "pending_at_reset", k, et[k] - eh[k], 0);
            eh[k] = 0; et[k] = 0; pos[k] = 0;
            for (int i = 0; i < 4; i++) due_f[k][i] = 1'b0;
        end
        rst_n = 1'b1;
        sync();
    endtask

    task automatic lit_check(input int k, input int n, input int exp [8], input int lastmask);
        check(logn[k] == n, "lit_count", k, logn[k], n);
        for (int i = 0; i < n && i < logn[k]; i++) begin
            check(logd[k][i] == exp[i], "lit_data", k, logd[k][i], exp[i]);
            check(logl[k][i] == lastmask[i], "lit_last", k, int'(logl[k][i]), int'(lastmask[i]));
        end
        logn[k] = 0;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                check(out_valid[k] == 1'b0, "valid_in_reset", k, int'(out_valid[k]), 0);
                check(out_data[k] == 0, "data_in_reset", k, out_data[k], 0);
            end else begin
                check(in_ready[k] == (!out_valid[k] || out_ready[k]), "in_ready", k,
                      int'(in_ready[k]), int'(!out_valid[k] || out_ready[k]));
                if (due_f[k][cyc % 4]) begin
                    due_f[k][cyc % 4] = 1'b0;
                    check(out_valid[k] && out_data[k] == due_v[k][cyc % 4], "latency", k,
                          out_valid[k] ? out_data[k] : -999, due_v[k][cyc % 4]);
                end
                if (out_valid[k]) begin
                    if (eh[k] == et[k]) begin
                        check(1'b0, "unexpected_out", k, out_data[k], 0);
                    end else begin
                        check(out_data[k] == eq_d[k][eh[k] % 512], "out_data", k, out_data[k], eq_d[k][eh[k] % 512]);
                        check(out_last[k] == eq_l[k][eh[k] % 512], "out_last", k, int'(out_last[k]), int'(eq_l[k][eh[k] % 512]));
                        if (out_ready[k]) begin
                            logd[k][logn[k] % 16] = out_data[k];
                            logl[k][logn[k] % 16] = out_last[k];
                            logn[k]++;
                            eh[k]++;
                        end
                    end
                end
            end
        end
    end

    task automatic stall_a();
        int t = 0;
        while (!out_valid[0] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check(out_valid[0] == 1'b1, "stall_wait", 0, int'(out_valid[0]), 1);
        out_ready[0] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
    endtask

    task automatic rand_frames(input int k);
        int v;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < hh[k] * ww[k] * cc[k]; i++) begin
                v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) - 2 : int'($urandom);
                send(k, v);
                repeat ($urandom_range(0, 1)) sync();
            end
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog inst=0: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; in_data[k] = 0; out_ready[k] = 1'b1;
            pos[k] = 0; eh[k] = 0; et[k] = 0; logn[k] = 0;
            for (int i = 0; i < 4; i++) due_f[k][i] = 1'b0;
        end
        do_reset();

        // 4x4x1 ramp
        for (int i = 0; i < 16; i++) send(0, i);
        repeat (3) sync();
        lit_check(0, 4, '{5, 7, 13, 15, 0, 0, 0, 0}, 8);

        // 2x2x2 signed compare, then INT_MIN against -1
        send(1, -3); send(1, 8); send(1, -1); send(1, -9);
        send(1, -7); send(1, 2); send(1, -2); send(1, -4);
        send(1, int'(32'h8000_0000)); send(1, int'(32'h8000_0000));
        send(1, -1);                  send(1, int'(32'h8000_0000));
        send(1, int'(32'h8000_0000)); send(1, int'(32'h8000_0000));
        send(1, int'(32'h8000_0000)); send(1, int'(32'h8000_0000));
        repeat (3) sync();
        lit_check(1, 4, '{-1, 8, -1, int'(32'h8000_0000), 0, 0, 0, 0}, 10);

        // backpressure on the first pooled value
        fork
            for (int i = 0; i < 16; i++) send(0, i);
            stall_a();
        join
        repeat (3) sync();
        lit_check(0, 4, '{5, 7, 13, 15, 0, 0, 0, 0}, 8);

        // odd 5x5: last row/col dropped, next frame aligned
        for (int i = 0; i < 25; i++) send(2, i);
        for (int i = 0; i < 25; i++) send(2, 100 + i);
        repeat (3) sync();
        lit_check(2, 8, '{6, 8, 16, 18, 106, 108, 116, 118}, 8'h88);

        // back-to-back frames
        for (int i = 0; i < 16; i++) send(0, i);
        for (int i = 0; i < 16; i++) send(0, 100 + i);
        repeat (3) sync();
        lit_check(0, 8, '{5, 7, 13, 15, 105, 107, 113, 115}, 8'h88);

        // reset mid-frame
        for (int i = 0; i < 6; i++) send(0, i);
        repeat (3) sync();
        logn[0] = 0;
        do_reset();
        for (int i = 0; i < 16; i++) send(0, i);
        repeat (3) sync();
        lit_check(0, 4, '{5, 7, 13, 15, 0, 0, 0, 0}, 8);

        // randomized values, gaps and backpressure on all instances
        rnd_on = 1'b1;
        fork
            begin
                fork
                    rand_frames(0);
                    rand_frames(1);
                    rand_frames(2);
                join
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    for (int k = 0; k < NI; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
                end
                for (int k = 0; k < NI; k++) out_ready[k] = 1'b1;
            end
        join
        repeat (6) sync();
        for (int k = 0; k < NI; k++) check(eh[k] == et[k], "queue_drained", k, et[k] - eh[k], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/maxpool2d_stream.md
Name: maxpool2d_stream

Overview:
2x2, stride-2 max-pooling stage placed directly downstream of conv2d_1. It consumes the conv feature map as a valid/ready stream of signed values in raster order, channel-interleaved (row, then col, then channel), and emits the pooled map in the same order. Pooling uses valid padding: a trailing odd row or column is dropped.

Parameters:
INPUT_HEIGHT, 26, feature-map rows (28x28 image after 3x3 valid conv); must be >= 2
INPUT_WIDTH, 26, feature-map columns; must be >= 2
CHANNELS, 2, depth; equals CONV2D_1_FILTERS_NUMBER
VALUE_BITS, 32, width of each signed two's-complement value

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  VALUE_BITS  signed input value
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  VALUE_BITS  signed pooled value
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  marks the final pooled value of a frame; qualified by out_valid

Behaviour:
- Reset (async assert, sync deassert) clears out_valid, out_last, out_data=0, and the row/col/channel counters. Line buffer and hold registers are not reset; they are always written before being read.
- Handshake: an input beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready. This is combinational, with no skid buffer.
- Output register holds its value while out_valid && !out_ready. It loads on the cycle after an accepting beat completes a 2x2 window; latency is 1 cycle.
- Counters: ch 0..CHANNELS-1, col 0..INPUT_WIDTH-1, row 0..INPUT_HEIGHT-1. They advance only on accepted beats. ch wraps into col, col into row, and row wraps to 0 at frame end. The next frame follows with no gap.
- PW = INPUT_WIDTH/2 and PH = INPUT_HEIGHT/2, using floor division.
- Per accepted beat, with col in range col < 2*PW and row < 2*PH:
  - col even: hold[ch] <= in_data.
  - col odd: h = smax(hold[ch], in_data).
    - row even: lbuf[(col/2)*CHANNELS+ch] <= h.
    - row odd: out_data <= smax(lbuf[(col/2)*CHANNELS+ch], h), out_valid <= 1.
- Beats with col == INPUT_WIDTH-1 (odd width) or row == INPUT_HEIGHT-1 (odd height) are accepted and discarded. They still advance the counters.
- smax is a signed comparison. Ties return either operand; the values are equal, so the result is identical. There is no width growth, and out_data equals the winning input bit-for-bit.
- out_last = 1 with the value for pooled row PH-1, pooled col PW-1, ch CHANNELS-1.
- out_valid drops after an out_ready handshake unless a new value is loaded in the same cycle. A simultaneous drain and load is legal and produces no bubble.
- A reset mid-frame discards any partial frame. The first beat after reset is treated as row 0, col 0, ch 0.
- Throughput: 1 beat/cycle when out_ready is held high. Output rate is 1/4 of input rate for even dimensions.
- Line buffer depth is PW*CHANNELS. It is a register array with combinational read.

Decomposition:
- Shared package nn_pkg holds:
  - VALUE_BITS default and a signed value_t typedef.
  - KERNEL_HEIGHT/WIDTH and filter-count constants.
  - POOL_SIZE=2.
  - Function pool_out_size(n) = n/2.
  - Function smax(a,b).
- One natural sub-module, pool_line_buffer: parameterised depth/width, one write port and one async read port. No reset.
- Counters, hold registers and the output register stay in maxpool2d_stream.

Test Plan:
- H=W=4, C=1, inputs 0..15 in raster order, out_ready=1 -> outputs 5, 7, 13, 15; out_last only on 15; each output appears 1 cycle after inputs 5, 7, 13, 15 are accepted.
- H=W=2, C=2, inputs (-3,8),(-1,-9),(-7,2),(-2,-4) as (ch0,ch1) per pixel -> outputs -1, 8 (signed compare; 0x80000000 never wins over -1).
- Same 4x4 stream with out_ready held low for 5 cycles after the first output -> out_data stays 5, in_ready low, no beats lost; outputs after release are 5, 7, 13, 15.
- H=W=5, C=1, inputs 0..24 -> outputs 6, 8, 16, 18 only; row 4 and col 4 are consumed; the next frame starts aligned at row 0.
- Two back-to-back 4x4 frames (0..15, then 100..115) -> 5, 7, 13, 15, 105, 107, 113, 115; out_last on 15 and 115.
- Assert rst_n low after 6 beats of a frame, then send a full 4x4 frame 0..15 -> exactly 5, 7, 13, 15; out_valid=0 during reset.
